// File: rtl/move_scheduler.sv
// ============================================================================
// move_scheduler : ring-buffered segment scheduler between SPI parser and DDA
// Optional: define MOVE_HALT_EN for the active-low halt_n flush input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module move_scheduler #(
   parameter int DEPTH_BITS = 2,
   parameter int DUR_W      = 64,
   parameter int INC_W      = 64
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   input  logic                  wr_dir,
   input  logic [DUR_W-1:0]      wr_duration,
   input  logic [INC_W-1:0]      wr_increment,
   input  logic [INC_W-1:0]      wr_incinc,
   output logic                  seg_valid,
   input  logic                  seg_ready,
   output logic                  seg_dir,
   output logic [DUR_W-1:0]      seg_duration,
   output logic [INC_W-1:0]      seg_increment,
   output logic [INC_W-1:0]      seg_incinc,
   input  logic                  seg_done,
`ifdef MOVE_HALT_EN
   input  logic                  halt_n,
`endif
   output logic [DEPTH_BITS:0]   level,
   output logic                  busy,
   output logic                  move_done
);

   localparam int                  c_DEPTH = 1 << DEPTH_BITS;
   localparam logic [DEPTH_BITS:0] c_FULL  = (DEPTH_BITS+1)'(c_DEPTH);
   localparam logic [DEPTH_BITS:0] c_ONE   = (DEPTH_BITS+1)'(1);
   localparam logic [1:0]          c_IDLE  = 2'd0;
   localparam logic [1:0]          c_ISSUE = 2'd1;
   localparam logic [1:0]          c_RUN   = 2'd2;

   logic [1:0]            r_state;
   logic [DEPTH_BITS-1:0] r_wr_ptr;
   logic [DEPTH_BITS-1:0] r_rd_ptr;
   logic [DEPTH_BITS:0]   r_level;
   logic                  r_seg_valid;
   logic                  r_seg_dir;
   logic [DUR_W-1:0]      r_seg_dur;
   logic [INC_W-1:0]      r_seg_inc;
   logic [INC_W-1:0]      r_seg_incinc;
   logic                  r_move_done;

   logic                  r_mem_dir    [c_DEPTH];
   logic [DUR_W-1:0]      r_mem_dur    [c_DEPTH];
   logic [INC_W-1:0]      r_mem_inc    [c_DEPTH];
   logic [INC_W-1:0]      r_mem_incinc [c_DEPTH];

   logic                  w_halt;
   logic                  w_done_fire;
   logic                  w_wr_fire;
   logic                  w_more;
   logic                  w_bypass;
   logic [DEPTH_BITS-1:0] w_rd_next;
   logic [DEPTH_BITS-1:0] w_ld_idx;
   logic                  w_ld_dir;
   logic [DUR_W-1:0]      w_ld_dur;
   logic [INC_W-1:0]      w_ld_inc;
   logic [INC_W-1:0]      w_ld_incinc;

`ifdef MOVE_HALT_EN
   assign w_halt = ~halt_n;
`else
   assign w_halt = 1'b0;
`endif

   assign w_done_fire = (r_state == c_RUN) & seg_done & ~w_halt;
   // A full buffer still accepts a write on the edge that retires the running entry.
   assign wr_ready    = ((r_level != c_FULL) | w_done_fire) & ~w_halt;
   assign w_wr_fire   = wr_valid & wr_ready;
   assign w_rd_next   = r_rd_ptr + 1'b1;
   assign w_more      = (r_level != c_ONE) | w_wr_fire;
   // Last entry retiring while a new one arrives: memory is not written yet, forward the inputs.
   assign w_bypass    = (r_state == c_RUN) & (r_level == c_ONE) & w_wr_fire;
   assign w_ld_idx    = (r_state == c_RUN) ? w_rd_next : r_rd_ptr;
   assign w_ld_dir    = w_bypass ? wr_dir       : r_mem_dir[w_ld_idx];
   assign w_ld_dur    = w_bypass ? wr_duration  : r_mem_dur[w_ld_idx];
   assign w_ld_inc    = w_bypass ? wr_increment : r_mem_inc[w_ld_idx];
   assign w_ld_incinc = w_bypass ? wr_incinc    : r_mem_incinc[w_ld_idx];

   always_ff @(posedge wb_clk_i) begin
      if (w_wr_fire) begin
         r_mem_dir[r_wr_ptr]    <= wr_dir;
         r_mem_dur[r_wr_ptr]    <= wr_duration;
         r_mem_inc[r_wr_ptr]    <= wr_increment;
         r_mem_incinc[r_wr_ptr] <= wr_incinc;
      end
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state      <= c_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_seg_valid  <= 1'b0;
         r_seg_dir    <= 1'b0;
         r_seg_dur    <= '0;
         r_seg_inc    <= '0;
         r_seg_incinc <= '0;
         r_move_done  <= 1'b0;
      end else if (w_halt) begin
         r_rd_ptr    <= r_wr_ptr;
         r_level     <= '0;
         r_state     <= c_IDLE;
         r_seg_valid <= 1'b0;
      end else begin
         if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
         case ({w_wr_fire, w_done_fire})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         case (r_state)
            c_IDLE: begin
               if (r_level != '0) begin
                  r_seg_dir    <= w_ld_dir;
                  r_seg_dur    <= w_ld_dur;
                  r_seg_inc    <= w_ld_inc;
                  r_seg_incinc <= w_ld_incinc;
                  r_seg_valid  <= 1'b1;
                  r_state      <= c_ISSUE;
               end
            end
            c_ISSUE: begin
               if (r_seg_valid & seg_ready) begin
                  r_seg_valid <= 1'b0;
                  r_state     <= c_RUN;
               end
            end
            c_RUN: begin
               if (seg_done) begin
                  r_rd_ptr    <= w_rd_next;
                  r_move_done <= ~r_move_done;
                  if (w_more) begin
                     r_seg_dir    <= w_ld_dir;
                     r_seg_dur    <= w_ld_dur;
                     r_seg_inc    <= w_ld_inc;
                     r_seg_incinc <= w_ld_incinc;
                     r_seg_valid  <= 1'b1;
                     r_state      <= c_ISSUE;
                  end else begin
                     r_state <= c_IDLE;
                  end
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign seg_valid     = r_seg_valid;
   assign seg_dir       = r_seg_dir;
   assign seg_duration  = r_seg_dur;
   assign seg_increment = r_seg_inc;
   assign seg_incinc    = r_seg_incinc;
   assign level         = r_level;
   assign busy          = (r_state != c_IDLE);
   assign move_done     = r_move_done;

endmodule

`default_nettype wire

// File: tb/tb_move_scheduler.sv
// ============================================================================
// tb_move_scheduler : directed self-checking bench for move_scheduler
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_move_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_valid = 1'b0;
   logic        wr_ready;
   logic        wr_dir = 1'b0;
   logic [63:0] wr_duration = '0;
   logic [63:0] wr_increment = '0;
   logic [63:0] wr_incinc = '0;
   logic        seg_valid;
   logic        seg_ready = 1'b0;
   logic        seg_dir;
   logic [63:0] seg_duration;
   logic [63:0] seg_increment;
   logic [63:0] seg_incinc;
   logic        seg_done = 1'b0;
   logic        halt_n = 1'b1;
   logic [2:0]  level;
   logic        busy;
   logic        move_done;

   int   nchk = 0;
   int   nerr = 0;
   logic exp_md = 1'b0;

   move_scheduler #(.DEPTH_BITS(2), .DUR_W(64), .INC_W(64)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dir(wr_dir),
      .wr_duration(wr_duration), .wr_increment(wr_increment), .wr_incinc(wr_incinc),
      .seg_valid(seg_valid), .seg_ready(seg_ready), .seg_dir(seg_dir),
      .seg_duration(seg_duration), .seg_increment(seg_increment), .seg_incinc(seg_incinc),
      .seg_done(seg_done),
`ifdef MOVE_HALT_EN
      .halt_n(halt_n),
`endif
      .level(level), .busy(busy), .move_done(move_done)
   );

   always #5 clk = ~clk;

   function automatic logic [192:0] seg_of(input int k);
      logic [63:0] d, i, ii;
      logic        dr;
      dr = k[0];
      d  = 64'(1000 + k * 7);
      i  = {32'hA5A5_0000 | 32'(k), 32'(k * 13)};
      ii = -64'(k + 1);
      return {dr, d, i, ii};
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input int k);
      logic [192:0] s;
      s = seg_of(k);
      {wr_dir, wr_duration, wr_increment, wr_incinc} = s;
   endtask

   task automatic test_reset;
      #12;
      nchk++; if (seg_valid !== 1'b0) begin nerr++; $display("FAIL rst_seg_valid got %b exp 0", seg_valid); end
      nchk++; if (level !== 3'd0) begin nerr++; $display("FAIL rst_level got %0d exp 0", level); end
      nchk++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
      nchk++; if ({busy, move_done} !== 2'b00) begin nerr++; $display("FAIL rst_busy_md got %b exp 00", {busy, move_done}); end
      nchk++; if (seg_duration !== 64'd0) begin nerr++; $display("FAIL rst_seg_dur got %h exp 0", seg_duration); end
      @(posedge clk); #1; rst = 1'b0;
      tick;
      nchk++; if ({level, wr_ready} !== 4'b0001) begin nerr++; $display("FAIL rst_release got %b exp 0001", {level, wr_ready}); end
   endtask

   task automatic test_single;
      seg_ready = 1'b1;
      wr_valid = 1'b1; wr_dir = 1'b1; wr_duration = 64'd10;
      wr_increment = 64'h100; wr_incinc = 64'hFFFF_FFFF_FFFF_FFFF;
      tick;
      wr_valid = 1'b0;
      nchk++; if ({level, seg_valid, busy} !== 5'b00100) begin nerr++; $display("FAIL single_after_wr got %b exp 00100", {level, seg_valid, busy}); end
      tick;
      nchk++; if ({level, seg_valid, busy} !== 5'b00111) begin nerr++; $display("FAIL single_issue got %b exp 00111", {level, seg_valid, busy}); end
      nchk++; if ({seg_dir, seg_duration, seg_increment, seg_incinc} !== {1'b1, 64'd10, 64'h100, 64'hFFFF_FFFF_FFFF_FFFF})
         begin nerr++; $display("FAIL single_fields got %h", {seg_dir, seg_duration, seg_increment, seg_incinc}); end
      tick;
      seg_ready = 1'b0;
      nchk++; if ({seg_valid, busy} !== 2'b01) begin nerr++; $display("FAIL single_run got %b exp 01", {seg_valid, busy}); end
      seg_done = 1'b1;
      tick;
      seg_done = 1'b0; exp_md = ~exp_md;
      nchk++; if ({level, move_done, busy} !== {3'd0, exp_md, 1'b0}) begin nerr++; $display("FAIL single_done got %b exp %b", {level, move_done, busy}, {3'd0, exp_md, 1'b0}); end
   endtask

   task automatic test_fill;
      seg_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin wr_valid = 1'b1; set_wr(40 + i); tick; end
      nchk++; if ({level, wr_ready} !== {3'd4, 1'b0}) begin nerr++; $display("FAIL fill_full got %b exp 1000", {level, wr_ready}); end
      set_wr(44);
      tick;
      wr_valid = 1'b0;
      nchk++; if (level !== 3'd4) begin nerr++; $display("FAIL fill_drop_level got %0d exp 4", level); end
      for (int i = 0; i < 4; i++) begin
         nchk++; if ({seg_valid, seg_dir, seg_duration, seg_increment, seg_incinc} !== {1'b1, seg_of(40 + i)})
            begin nerr++; $display("FAIL fill_order[%0d] got %h exp %h", i, {seg_dir, seg_duration, seg_increment, seg_incinc}, seg_of(40 + i)); end
         seg_ready = 1'b1; tick; seg_ready = 1'b0;
         nchk++; if (seg_valid !== 1'b0) begin nerr++; $display("FAIL fill_accept[%0d] got %b exp 0", i, seg_valid); end
         seg_done = 1'b1; tick; seg_done = 1'b0; exp_md = ~exp_md;
         nchk++; if ({level, move_done} !== {3'(3 - i), exp_md}) begin nerr++; $display("FAIL fill_done[%0d] got %b exp %b", i, {level, move_done}, {3'(3 - i), exp_md}); end
      end
      tick;
      nchk++; if ({seg_valid, busy, level} !== 5'b00000) begin nerr++; $display("FAIL fill_empty got %b exp 00000", {seg_valid, busy, level}); end
   endtask

   task automatic test_full_concurrent;
      seg_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin wr_valid = 1'b1; set_wr(50 + i); tick; end
      wr_valid = 1'b0;
      seg_ready = 1'b1; tick; seg_ready = 1'b0;
      nchk++; if ({level, wr_ready, busy} !== 5'b10001) begin nerr++; $display("FAIL conc_full got %b exp 10001", {level, wr_ready, busy}); end
      wr_valid = 1'b1; set_wr(54); seg_done = 1'b1;
      #1;
      nchk++; if (wr_ready !== 1'b1) begin nerr++; $display("FAIL conc_wr_ready got %b exp 1", wr_ready); end
      tick;
      wr_valid = 1'b0; seg_done = 1'b0; exp_md = ~exp_md;
      nchk++; if (level !== 3'd4) begin nerr++; $display("FAIL conc_level got %0d exp 4", level); end
      for (int i = 1; i < 5; i++) begin
         nchk++; if ({seg_valid, seg_dir, seg_duration, seg_increment, seg_incinc} !== {1'b1, seg_of(50 + i)})
            begin nerr++; $display("FAIL conc_order[%0d] got %h exp %h", i, {seg_dir, seg_duration, seg_increment, seg_incinc}, seg_of(50 + i)); end
         seg_ready = 1'b1; tick; seg_ready = 1'b0;
         seg_done = 1'b1; tick; seg_done = 1'b0; exp_md = ~exp_md;
      end
      nchk++; if ({level, move_done, busy} !== {3'd0, exp_md, 1'b0}) begin nerr++; $display("FAIL conc_end got %b exp %b", {level, move_done, busy}, {3'd0, exp_md, 1'b0}); end
   endtask

   task automatic test_back_to_back;
      int   wi, ri, dn, lvl, pend;
      logic wv, sd;
      wi = 0; ri = 0; dn = 0; lvl = 0; pend = 0;
      seg_ready = 1'b1;
      for (int cyc = 0; cyc < 300 && dn < 10; cyc++) begin
         wv = (wi < 10) && (lvl < 4);
         sd = (pend == 1);
         if (pend > 0) pend--;
         wr_valid = wv; if (wv) set_wr(20 + wi);
         seg_done = sd;
         tick;
         if (wv) wi++;
         if (sd) begin dn++; exp_md = ~exp_md; end
         lvl = lvl + int'(wv) - int'(sd);
         nchk++; if (level !== 3'(lvl)) begin nerr++; $display("FAIL b2b_level cyc %0d got %0d exp %0d", cyc, level, lvl); end
         if (sd && lvl > 0) begin
            nchk++; if (seg_valid !== 1'b1) begin nerr++; $display("FAIL b2b_bubble cyc %0d got %b exp 1", cyc, seg_valid); end
         end
         if (seg_valid === 1'b1) begin
            nchk++; if ({seg_dir, seg_duration, seg_increment, seg_incinc} !== seg_of(20 + ri))
               begin nerr++; $display("FAIL b2b_fields[%0d] got %h exp %h", ri, {seg_dir, seg_duration, seg_increment, seg_incinc}, seg_of(20 + ri)); end
            ri++;
            pend = 2;
         end
      end
      wr_valid = 1'b0; seg_done = 1'b0; seg_ready = 1'b0;
      nchk++; if (dn != 10 || ri != 10) begin nerr++; $display("FAIL b2b_count got done %0d issued %0d exp 10", dn, ri); end
      nchk++; if ({level, busy, move_done} !== {3'd0, 1'b0, exp_md}) begin nerr++; $display("FAIL b2b_end got %b exp %b", {level, busy, move_done}, {3'd0, 1'b0, exp_md}); end
   endtask

`ifdef MOVE_HALT_EN
   task automatic test_halt;
      seg_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin wr_valid = 1'b1; set_wr(60 + i); tick; end
      wr_valid = 1'b0;
      seg_ready = 1'b1; tick; seg_ready = 1'b0;
      halt_n = 1'b0; wr_valid = 1'b1; set_wr(63); seg_done = 1'b1;
      #1;
      nchk++; if (wr_ready !== 1'b0) begin nerr++; $display("FAIL halt_wr_ready got %b exp 0", wr_ready); end
      tick;
      halt_n = 1'b1; wr_valid = 1'b0; seg_done = 1'b0;
      nchk++; if ({level, seg_valid, busy, move_done} !== {3'd0, 2'b00, exp_md}) begin nerr++; $display("FAIL halt_flush got %b exp %b", {level, seg_valid, busy, move_done}, {3'd0, 2'b00, exp_md}); end
      tick;
      nchk++; if ({level, seg_valid} !== 4'b0000) begin nerr++; $display("FAIL halt_idle got %b exp 0000", {level, seg_valid}); end
      wr_valid = 1'b1; set_wr(64); tick; wr_valid = 1'b0;
      tick;
      nchk++; if ({seg_valid, seg_dir, seg_duration, seg_increment, seg_incinc} !== {1'b1, seg_of(64)})
         begin nerr++; $display("FAIL halt_resume got %h exp %h", {seg_dir, seg_duration, seg_increment, seg_incinc}, seg_of(64)); end
      seg_ready = 1'b1; tick; seg_ready = 1'b0;
      seg_done = 1'b1; tick; seg_done = 1'b0; exp_md = ~exp_md;
      nchk++; if ({level, move_done} !== {3'd0, exp_md}) begin nerr++; $display("FAIL halt_done got %b exp %b", {level, move_done}, {3'd0, exp_md}); end
   endtask
`endif

   task automatic test_reset_mid;
      wr_valid = 1'b1; set_wr(70); tick; wr_valid = 1'b0;
      tick;
      nchk++; if (seg_valid !== 1'b1) begin nerr++; $display("FAIL rmid_issue got %b exp 1", seg_valid); end
      #2 rst = 1'b1;
      #1;
      exp_md = 1'b0;
      nchk++; if ({seg_valid, level, wr_ready, busy, move_done} !== {1'b0, 3'd0, 1'b1, 1'b0, 1'b0})
         begin nerr++; $display("FAIL rmid_async got %b exp 0000100", {seg_valid, level, wr_ready, busy, move_done}); end
      @(posedge clk); #1; rst = 1'b0;
      tick;
      nchk++; if ({seg_valid, level, wr_ready, busy} !== {1'b0, 3'd0, 1'b1, 1'b0})
         begin nerr++; $display("FAIL rmid_release got %b exp 000010", {seg_valid, level, wr_ready, busy}); end
   endtask

   initial begin
      test_reset;
      test_single;
      test_fill;
      test_full_concurrent;
      test_back_to_back;
`ifdef MOVE_HALT_EN
      test_halt;
`endif
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", nchk, nerr);
      $finish;
   end

endmodule

`default_nettype wire
